// File: rtl/req_pkg.sv
// Shared request-stream types for the issuer and the aggregation hierarchy.
package req_pkg;

  localparam int REQ_DATA_W = 16;
  localparam int REQ_ID_W   = 4;

  typedef struct packed {
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_ID_W-1:0]   id;
    logic                  valid;
  } request_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with separate occupancy count; no bypass, so a push is
// visible at the head only from the following cycle.
module req_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ready,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers are log2(DEPTH) wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign ready = (count < CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/req_issuer.sv
// Buffers command words, issues one id-stamped registered request per cycle
// and captures the hierarchy's combinational result one cycle later.
module req_issuer
  import req_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int ID_START = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REQ_DATA_W-1:0]     cmd_data,
  input  logic                      issue_en,
  output request_t                  req,
  input  logic [WIDTH-1:0]          rsp_in,
  output logic                      rsp_valid,
  output logic [REQ_ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  // Command handshake: a word transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on registered occupancy,
  // so it never reflects a pop happening in the same cycle.
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [REQ_DATA_W-1:0] head;
  logic [REQ_ID_W-1:0]   id_ctr;

  assign push = cmd_valid && cmd_ready;
  assign pop  = issue_en && !fifo_empty;

  req_fifo #(
    .W     (REQ_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cmd_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .ready     (cmd_ready),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req    <= '0;
      id_ctr <= REQ_ID_W'(ID_START);
    end else if (pop) begin
      req.data  <= head;
      req.id    <= id_ctr;
      req.valid <= 1'b1;
      id_ctr    <= id_ctr + REQ_ID_W'(1);
    end else begin
      req.valid <= 1'b0;
    end
  end

  // rsp_in is a combinational function of req, so sampling it here pairs it
  // with the id that req carried in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= req.valid;
      if (req.valid) begin
        rsp_id   <= req.id;
        rsp_data <= rsp_in;
      end
    end
  end

endmodule

// File: doc/req_issuer.md
# req_issuer

Initiator for the `request_t` request stream. It buffers incoming command words in a small FIFO and drives one registered `request_t` per cycle toward the aggregation hierarchy, stamping each request with a rolling 4-bit id. It captures the combinational result returned by that hierarchy and reports it, tagged with the issued id, one cycle later. It sits between the command source and the hierarchy top's `upstream`/`combined` ports.

## Interface
- `WIDTH`, 16: width of the returned result (`rsp_in`, `rsp_data`).
- `DEPTH`, 4: command FIFO depth. Must be a power of two, ≥2.
- `ID_START`, 0: id value loaded at reset (0..15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command word offered.
- `cmd_ready`  out  1  FIFO can accept; combinational from registered count (`count < DEPTH`).
- `cmd_data`  in  16  payload, becomes `req.data`.
- `issue_en`  in  1  permits a FIFO pop this cycle.
- `req`  out  `request_t` (21)  registered request `{data[15:0], id[3:0], valid}`.
- `rsp_in`  in  WIDTH  result from the hierarchy; combinational function of `req`.
- `rsp_valid`  out  1  registered; result captured.
- `rsp_id`  out  4  id of the request that produced `rsp_data`.
- `rsp_data`  out  WIDTH  captured `rsp_in`.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `cmd_valid && cmd_ready` writes `cmd_data` at the write pointer.
- Pop: `issue_en && count != 0`. Reads the head entry and loads `req <= {head, id_ctr, 1'b1}`. `id_ctr <= id_ctr + 1` mod 16, wrapping 15→0.
- No pop in a cycle: `req.valid <= 0`. `req.data` and `req.id` hold their previous values.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: `cmd_ready = 0`, including in a cycle where a pop occurs. There is no pass-through of ready.
- Pointers wrap modulo DEPTH. Count is tracked separately so that full and empty are unambiguous.
- Response: `rsp_valid <= req.valid`. When `req.valid` is high, `rsp_id <= req.id` and `rsp_data <= rsp_in`. Otherwise `rsp_id` and `rsp_data` hold.
- Id reported: `rsp_id` is the id as issued. The hierarchy's internal id+1 staging is invisible here.
- No FIFO bypass: an empty-FIFO command always spends one cycle in storage.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - `req` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `fifo_count` = 0.
  - `cmd_ready` = 1.
  - `id_ctr` = ID_START; pointers = 0.
- Latency with an empty FIFO and `issue_en` held high:
  - Command handshake in cycle 0.
  - `req.valid` high in cycle 2.
  - `rsp_valid` high in cycle 3.
- Throughput: one request per cycle while FIFO is non-empty and `issue_en` = 1.
- `issue_en` low: the head entry is retained and `req.valid` = 0 from the next cycle.
- Reset mid-stream: all FIFO contents are discarded, in-flight `req` and `rsp` are dropped, and the id restarts at ID_START.

## Structure
- Shared package `req_pkg` holds:
  - `request_t`,
  - `REQ_DATA_W` = 16,
  - `REQ_ID_W` = 4.
- The hierarchy top and `req_issuer` both import it.
- One sub-module: `req_fifo`, a synchronous FIFO parameterised by width and DEPTH, with push/pop/count and no bypass. `req_issuer` adds the id counter, the request register and the response capture.

## Test plan
- Reset, then one command 0xABCD with `issue_en` = 1:
  - cycle 2: `req` = `{0xABCD, 0, 1}`;
  - cycle 3: `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = `rsp_in` sampled in cycle 2.
- 20 back-to-back commands with `issue_en` = 1: ids 0..15, then 0..3; one `req.valid` per cycle; no gaps after the pipeline fills.
- `issue_en` = 0 while pushing 5 commands, DEPTH = 4:
  - `cmd_ready` drops after 4 pushes;
  - `fifo_count` = 4; the 5th word is stalled, not lost.
  - Raise `issue_en`: words are issued in order and `cmd_ready` returns the cycle after the first pop.
- Full FIFO with simultaneous pop and offered push: push is refused that cycle (`cmd_ready` = 0) and `fifo_count` goes 4→3.
- `issue_en` toggled 1,0,1: `req.valid` pattern 1,0,1 and `req.data` holds during the gap. `rsp_valid` mirrors the pattern one cycle later.
- Assert `rst_n` = 0 with 3 entries queued and `req.valid` = 1:
  - outputs go to 0 immediately (asynchronously);
  - after release the next issued id is ID_START and none of the flushed data appears.
